// File: rtl/basic_timer_core.sv
// rtl/basic_timer_core.sv - register-programmed up-counting basic timer with prescaler and auto-reload
module basic_timer_core #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ld_sel,
    input  logic [DATA_W-1:0] data_in,
    input  logic              isr_clr,
    output logic              uif,
    output logic              upd_evt,
    output logic [CNT_W-1:0]  cnt
);

    localparam logic [3:0] SEL_CR1  = 4'h0;
    localparam logic [3:0] SEL_DIER = 4'h1;
    localparam logic [3:0] SEL_SR   = 4'h2;
    localparam logic [3:0] SEL_EGR  = 4'h3;
    localparam logic [3:0] SEL_CNT  = 4'h4;
    localparam logic [3:0] SEL_PSC  = 4'h5;
    localparam logic [3:0] SEL_ARR  = 4'h6;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Control and status register bits
    logic cen_q, cen_d;
    logic arpe_q, arpe_d;
    logic uie_q, uie_d;
    logic sr_uif_q, sr_uif_d;

    // Preload / shadow pairs for prescaler and auto-reload
    logic [CNT_W-1:0] psc_pre_q, psc_pre_d;
    logic [CNT_W-1:0] psc_sh_q, psc_sh_d;
    logic [CNT_W-1:0] arr_pre_q, arr_pre_d;
    logic [CNT_W-1:0] arr_sh_q, arr_sh_d;

    // Counting state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;

    // Registered outputs
    logic uif_q, uif_d;
    logic upd_evt_q;

    // Write decode
    logic wr_cr1, wr_dier, wr_sr, wr_egr, wr_cnt, wr_psc, wr_arr;
    logic ug;

    // Counting datapath
    logic             tick;
    logic [CNT_W-1:0] arr_eff;
    logic             nat_upd;
    logic             upd;

    // Only the low bits of most registers are meaningful; the rest of the bus is folded here
    logic unused_data_bits;
    assign unused_data_bits = ^data_in;

    // Register write decode; select 7 and 8..F decode to nothing
    always_comb begin
        wr_cr1  = (ld_sel == SEL_CR1);
        wr_dier = (ld_sel == SEL_DIER);
        wr_sr   = (ld_sel == SEL_SR);
        wr_egr  = (ld_sel == SEL_EGR);
        wr_cnt  = (ld_sel == SEL_CNT);
        wr_psc  = (ld_sel == SEL_PSC);
        wr_arr  = (ld_sel == SEL_ARR);
        ug      = wr_egr && data_in[0];
    end

    // Prescaler tick, effective reload value and update event detection
    always_comb begin
        tick    = cen_q && (psc_cnt_q == psc_sh_q);
        arr_eff = arpe_q ? arr_sh_q : arr_pre_q;
        // >= rather than == so a reload value lowered below the count still wraps on the next tick
        nat_upd = tick && (cnt_q >= arr_eff);
        // A UG write landing on a natural update merges into one event
        upd     = nat_upd || ug;
    end

    // Next-state for control registers and preloads
    always_comb begin
        cen_d     = cen_q;
        arpe_d    = arpe_q;
        uie_d     = uie_q;
        psc_pre_d = psc_pre_q;
        arr_pre_d = arr_pre_q;
        if (wr_cr1) begin
            cen_d  = data_in[0];
            arpe_d = data_in[7];
        end
        if (wr_dier) begin
            uie_d = data_in[0];
        end
        if (wr_psc) begin
            psc_pre_d = data_in[CNT_W-1:0];
        end
        if (wr_arr) begin
            arr_pre_d = data_in[CNT_W-1:0];
        end
    end

    // Next-state for shadows, status flag and registered irq
    always_comb begin
        psc_sh_d = psc_sh_q;
        arr_sh_d = arr_sh_q;
        sr_uif_d = sr_uif_q;
        if (upd) begin
            psc_sh_d = psc_pre_q;
            arr_sh_d = arr_pre_q;
        end
        // Setting the flag beats any clear arriving in the same cycle
        if (upd) begin
            sr_uif_d = 1'b1;
        end else if (isr_clr || (wr_sr && !data_in[0])) begin
            sr_uif_d = 1'b0;
        end
        uif_d = sr_uif_d && uie_d;
    end

    // Next-state for prescaler counter and main counter
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        cnt_d     = cnt_q;
        if (ug) begin
            psc_cnt_d = '0;
        end else if (cen_q) begin
            psc_cnt_d = (psc_cnt_q == psc_sh_q) ? '0 : (psc_cnt_q + CNT_ONE);
        end
        // A direct CNT write overrides the tick but leaves the prescaler phase alone
        if (ug) begin
            cnt_d = '0;
        end else if (wr_cnt) begin
            cnt_d = data_in[CNT_W-1:0];
        end else if (tick) begin
            cnt_d = nat_upd ? '0 : (cnt_q + CNT_ONE);
        end
    end

    // Control registers and preloads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cen_q     <= 1'b0;
            arpe_q    <= 1'b0;
            uie_q     <= 1'b0;
            psc_pre_q <= '0;
            arr_pre_q <= '1;
        end else begin
            cen_q     <= cen_d;
            arpe_q    <= arpe_d;
            uie_q     <= uie_d;
            psc_pre_q <= psc_pre_d;
            arr_pre_q <= arr_pre_d;
        end
    end

    // Shadow registers and status flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_sh_q <= '0;
            arr_sh_q <= '1;
            sr_uif_q <= 1'b0;
        end else begin
            psc_sh_q <= psc_sh_d;
            arr_sh_q <= arr_sh_d;
            sr_uif_q <= sr_uif_d;
        end
    end

    // Prescaler counter and main counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    // Registered interrupt request and single-cycle update pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uif_q     <= 1'b0;
            upd_evt_q <= 1'b0;
        end else begin
            uif_q     <= uif_d;
            upd_evt_q <= upd;
        end
    end

    assign uif     = uif_q;
    assign upd_evt = upd_evt_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_basic_timer_core.sv
// tb/tb_basic_timer_core.sv - directed self-checking bench for basic_timer_core
module tb_basic_timer_core;

    logic        clk;
    logic        rst;
    logic [3:0]  ld_sel;
    logic [31:0] data_in;
    logic        isr_clr;
    logic        uif;
    logic        upd_evt;
    logic [15:0] cnt;

    int n_checks;
    int n_fail;
    int cyc;

    basic_timer_core #(.CNT_W(16), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_sel  (ld_sel),
        .data_in (data_in),
        .isr_clr (isr_clr),
        .uif     (uif),
        .upd_evt (upd_evt),
        .cnt     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [31:0] d);
        ld_sel  = sel;
        data_in = d;
        step();
        ld_sel  = 4'h7;
        data_in = 32'h0;
    endtask

    task automatic wait_upd(input int max_cyc, output int cycles);
        cycles = 0;
        while (1) begin
            step();
            cycles++;
            if (upd_evt === 1'b1) break;
            if (cycles >= max_cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_upd timeout observed=%0d expected<%0d", cycles, max_cyc);
                break;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        ld_sel   = 4'h7;
        data_in  = 32'h0;
        isr_clr  = 1'b0;

        // Reset state
        #1;
        chk("rst_uif", uif, 0);
        chk("rst_upd", upd_evt, 0);
        chk("rst_cnt", cnt, 0);
        step(); step();
        rst = 1'b1;
        step();
        chk("rel_uif", uif, 0);
        chk("rel_upd", upd_evt, 0);
        chk("rel_cnt", cnt, 0);

        // Default PSC=0, ARR=FFFF: first update 65536 cycles after CEN
        wr(4'h0, 32'h1);
        wait_upd(70000, cyc);
        chk("dflt_period", cyc, 65536);
        chk("dflt_uif_masked", uif, 0);
        chk("dflt_cnt_wrap", cnt, 0);
        wr(4'h0, 32'h0);
        wr(4'h2, 32'h0);

        // Init sequence: ARPE, PSC=3, ARR=4, UIE, UG, then enable
        wr(4'h0, 32'h80);
        wr(4'h5, 32'd3);
        wr(4'h6, 32'd4);
        wr(4'h1, 32'h1);
        wr(4'h3, 32'h1);
        chk("ug_upd", upd_evt, 1);
        chk("ug_uif", uif, 1);
        chk("ug_cnt", cnt, 0);
        isr_clr = 1'b1;
        step();
        isr_clr = 1'b0;
        chk("clr_uif", uif, 0);
        chk("clr_upd", upd_evt, 0);
        wr(4'h0, 32'h81);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("init_cnt_%0d", k), cnt, (k < 20) ? (k / 4) : 0);
            chk($sformatf("init_upd_%0d", k), upd_evt, (k == 20) ? 1 : 0);
            chk($sformatf("init_uif_%0d", k), uif, (k == 20) ? 1 : 0);
        end
        wr(4'h0, 32'h80);
        isr_clr = 1'b1;
        step();
        isr_clr = 1'b0;

        // Preload: ARPE=1, PSC=0, ARR=9, lower ARR to 2 mid-period
        wr(4'h5, 32'd0);
        wr(4'h6, 32'd9);
        wr(4'h3, 32'h1);
        wr(4'h0, 32'h81);
        step(); step(); step();
        chk("pre_cnt3", cnt, 3);
        wr(4'h6, 32'd2);
        wait_upd(40, cyc);
        chk("pre_finish10", cyc, 6);
        wait_upd(40, cyc);
        chk("pre_period3a", cyc, 3);
        wait_upd(40, cyc);
        chk("pre_period3b", cyc, 3);

        // No preload: ARPE=0, ARR=9, cnt=7, ARR=3 forces update on next tick
        wr(4'h0, 32'h00);
        wr(4'h6, 32'd9);
        wr(4'h4, 32'd7);
        chk("np_cnt7", cnt, 7);
        wr(4'h6, 32'd3);
        wr(4'h0, 32'h01);
        wait_upd(40, cyc);
        chk("np_next_tick", cyc, 1);
        chk("np_cnt0", cnt, 0);
        wait_upd(40, cyc);
        chk("np_period4", cyc, 4);

        // Clear race: isr_clr on the update edge loses
        isr_clr = 1'b1;
        step();
        isr_clr = 1'b0;
        chk("race_pre_clr", uif, 0);
        step(); step();
        isr_clr = 1'b1;
        step();
        isr_clr = 1'b0;
        chk("race_upd", upd_evt, 1);
        chk("race_uif", uif, 1);
        step();
        chk("race_uif_hold", uif, 1);
        isr_clr = 1'b1;
        step();
        isr_clr = 1'b0;
        chk("solo_clr_uif", uif, 0);
        wr(4'h2, 32'h1);
        chk("sr_w1_noeffect", uif, 0);

        // UG coinciding with a natural update gives one pulse
        wr(4'h3, 32'h1);
        chk("ugnat_upd", upd_evt, 1);
        chk("ugnat_cnt", cnt, 0);
        step();
        chk("ugnat_single", upd_evt, 0);
        chk("ugnat_cnt1", cnt, 1);

        // ARR=0: update on every tick, cnt pinned at 0
        wr(4'h6, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("arr0_upd_%0d", k), upd_evt, 1);
            chk($sformatf("arr0_cnt_%0d", k), cnt, 0);
        end

        // Async reset mid-count at cnt=3
        wr(4'h0, 32'h0);
        wr(4'h6, 32'd9);
        wr(4'h4, 32'd2);
        wr(4'h0, 32'h1);
        step();
        chk("ar_cnt3", cnt, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cnt", cnt, 0);
        chk("ar_uif", uif, 0);
        chk("ar_upd", upd_evt, 0);
        step(); step();
        rst = 1'b1;
        step();
        chk("ar_frozen_cnt", cnt, 0);
        chk("ar_no_irq", uif, 0);
        chk("ar_no_upd", upd_evt, 0);
        wr(4'h0, 32'h1);
        step();
        chk("ar_psc0_cnt", cnt, 1);
        wr(4'h3, 32'h1);
        chk("ar_ug_upd", upd_evt, 1);
        chk("ar_ug_uie_off", uif, 0);
        chk("ar_ug_cnt", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
